s_term_cfg_pipe: RTL and testbench

S_TERM_CFG_PIPE -- requirements
Module: s_term_cfg_pipe

---
 rtl/s_term_cfg_pkg.sv | 22 ++
 rtl/clk_buf.sv | 9 +
 rtl/frame_pipe_stage.sv | 19 +
 rtl/s_term_cfg_pipe.sv | 118 +++++++++++
 tb/tb_s_term_cfg_pipe.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/s_term_cfg_pkg.sv
// rtl/s_term_cfg_pkg.sv - shared limits, counter constants and helpers for the terminal config pipe
package s_term_cfg_pkg;

  localparam int MIN_PIPE_STAGES  = 0;
  localparam int MAX_PIPE_STAGES  = 4;
  localparam int MIN_LOCAL_FRAMES = 1;

  localparam int                       WRITE_COUNT_W   = 16;
  localparam logic [WRITE_COUNT_W-1:0] WRITE_COUNT_MAX = 16'hFFFF;

  // Classification of the local rising-edge vector in one cycle
  typedef enum logic [1:0] {
    STROBE_IDLE   = 2'd0,
    STROBE_SINGLE = 2'd1,
    STROBE_MULTI  = 2'd2
  } strobeClass_e;

  function automatic int frameIdxWidth(input int frames);
    return (frames > 1) ? $clog2(frames) : 1;
  endfunction

endpackage

// File: rtl/clk_buf.sv
// rtl/clk_buf.sv - clock buffer cell, behavioural view
module clk_buf (
  input  logic A,
  output logic X
);

  assign X = A;

endmodule

// File: rtl/frame_pipe_stage.sv
// rtl/frame_pipe_stage.sv - one register slice of the frame data/strobe pass-through
module frame_pipe_stage #(
  parameter int WIDTH = 52
) (
  input  logic             UserCLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge UserCLK or posedge Reset) begin
    if (Reset) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/s_term_cfg_pipe.sv
// rtl/s_term_cfg_pipe.sv - terminal config tile: delayed frame pass-through plus local frame capture
module s_term_cfg_pipe
  import s_term_cfg_pkg::*;
#(
  parameter int FRAME_BITS_PER_ROW = 32,
  parameter int MAX_FRAMES_PER_COL = 20,
  parameter int PIPE_STAGES        = 1,
  parameter int LOCAL_FRAMES       = 2
) (
  input  logic                                       UserCLK,
  input  logic                                       Reset,
  output logic                                       UserCLKo,
  input  logic [FRAME_BITS_PER_ROW-1:0]              FrameData,
  output logic [FRAME_BITS_PER_ROW-1:0]              FrameData_O,
  input  logic [MAX_FRAMES_PER_COL-1:0]              FrameStrobe,
  output logic [MAX_FRAMES_PER_COL-1:0]              FrameStrobe_O,
  output logic [LOCAL_FRAMES*FRAME_BITS_PER_ROW-1:0] ConfigBits,
  output logic                                       CfgWrite,
  output logic [frameIdxWidth(LOCAL_FRAMES)-1:0]     CfgFrameIdx,
  output logic [WRITE_COUNT_W-1:0]                   WriteCount,
  output logic                                       StrobeErr
);

  localparam int IDX_W = frameIdxWidth(LOCAL_FRAMES);
  localparam int BUS_W = FRAME_BITS_PER_ROW + MAX_FRAMES_PER_COL;

  if (PIPE_STAGES < MIN_PIPE_STAGES || PIPE_STAGES > MAX_PIPE_STAGES) begin : gBadStages
    $error("s_term_cfg_pipe: PIPE_STAGES out of range");
  end
  if (LOCAL_FRAMES < MIN_LOCAL_FRAMES || LOCAL_FRAMES > MAX_FRAMES_PER_COL) begin : gBadLocal
    $error("s_term_cfg_pipe: LOCAL_FRAMES out of range");
  end

  clk_buf uClkBuf (
    .A (UserCLK),
    .X (UserCLKo)
  );

  // Data and strobe travel together so they stay aligned through every stage
  logic [BUS_W-1:0] stageBus [PIPE_STAGES+1];

  assign stageBus[0] = {FrameStrobe, FrameData};

  for (genvar i = 0; i < PIPE_STAGES; i++) begin : gStage
    frame_pipe_stage #(
      .WIDTH (BUS_W)
    ) uStage (
      .UserCLK (UserCLK),
      .Reset   (Reset),
      .d       (stageBus[i]),
      .q       (stageBus[i+1])
    );
  end

  assign {FrameStrobe_O, FrameData_O} = stageBus[PIPE_STAGES];

  logic [LOCAL_FRAMES-1:0]       prevStrobe;
  logic [LOCAL_FRAMES-1:0]       localRise;
  logic                          strobeMulti;
  logic                          captureEn;
  logic [IDX_W-1:0]              riseIdx;
  strobeClass_e                  riseClass;
  logic [FRAME_BITS_PER_ROW-1:0] cfgSlice [LOCAL_FRAMES];

  assign localRise   = FrameStrobe[LOCAL_FRAMES-1:0] & ~prevStrobe;
  // x & (x-1) is nonzero exactly when more than one bit of x is set
  assign strobeMulti = |(FrameStrobe & (FrameStrobe - MAX_FRAMES_PER_COL'(1)));
  assign captureEn   = (riseClass == STROBE_SINGLE);

  always_comb begin
    riseIdx   = '0;
    riseClass = STROBE_IDLE;
    for (int k = 0; k < LOCAL_FRAMES; k++) begin
      if (localRise[k]) begin
        riseIdx = IDX_W'(k);
      end
    end
    if (localRise != '0) begin
      if (|(localRise & (localRise - LOCAL_FRAMES'(1)))) begin
        riseClass = STROBE_MULTI;
      end else begin
        riseClass = STROBE_SINGLE;
      end
    end
  end

  // prevStrobe resets high so a strobe already asserted at reset release is not an edge
  always_ff @(posedge UserCLK or posedge Reset) begin
    if (Reset) begin
      prevStrobe  <= '1;
      CfgWrite    <= 1'b0;
      CfgFrameIdx <= '0;
      WriteCount  <= '0;
      StrobeErr   <= 1'b0;
      for (int k = 0; k < LOCAL_FRAMES; k++) begin
        cfgSlice[k] <= '0;
      end
    end else begin
      prevStrobe <= FrameStrobe[LOCAL_FRAMES-1:0];
      CfgWrite   <= captureEn;
      if (captureEn) begin
        cfgSlice[riseIdx] <= FrameData;
        CfgFrameIdx       <= riseIdx;
        if (WriteCount != WRITE_COUNT_MAX) begin
          WriteCount <= WriteCount + WRITE_COUNT_W'(1);
        end
      end
      if (strobeMulti) begin
        StrobeErr <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < LOCAL_FRAMES; k++) begin : gCfg
    assign ConfigBits[k*FRAME_BITS_PER_ROW +: FRAME_BITS_PER_ROW] = cfgSlice[k];
  end

endmodule

// File: tb/tb_s_term_cfg_pipe.sv
// tb/tb_s_term_cfg_pipe.sv - scoreboard bench for s_term_cfg_pipe (two and zero pipe stages)
module tb_s_term_cfg_pipe;

  logic        UserCLK = 1'b0;
  logic        Reset;
  logic [31:0] FrameData;
  logic [19:0] FrameStrobe;

  logic        clkO2, clkO0;
  logic [31:0] data2, data0;
  logic [19:0] strobe2, strobe0;
  logic [63:0] cfg2, cfg0;
  logic        wr2, wr0, idx2, idx0, err2, err0;
  logic [15:0] cnt2, cnt0;

  always #5 UserCLK = ~UserCLK;

  s_term_cfg_pipe #(.PIPE_STAGES(2)) dut2 (
    .UserCLK(UserCLK), .Reset(Reset), .UserCLKo(clkO2),
    .FrameData(FrameData), .FrameData_O(data2),
    .FrameStrobe(FrameStrobe), .FrameStrobe_O(strobe2),
    .ConfigBits(cfg2), .CfgWrite(wr2), .CfgFrameIdx(idx2),
    .WriteCount(cnt2), .StrobeErr(err2)
  );

  s_term_cfg_pipe #(.PIPE_STAGES(0)) dut0 (
    .UserCLK(UserCLK), .Reset(Reset), .UserCLKo(clkO0),
    .FrameData(FrameData), .FrameData_O(data0),
    .FrameStrobe(FrameStrobe), .FrameStrobe_O(strobe0),
    .ConfigBits(cfg0), .CfgWrite(wr0), .CfgFrameIdx(idx0),
    .WriteCount(cnt0), .StrobeErr(err0)
  );

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [19:0] s;
  } pipeEnt_t;

  typedef struct packed {
    logic        write;
    logic        idx;
    logic [63:0] cfg;
    logic [15:0] cnt;
    logic        err;
  } capEnt_t;

  pipeEnt_t pipeQ[$];
  capEnt_t  capQ[$];

  logic [1:0]  mPrev;
  logic [63:0] mCfg;
  logic        mIdx;
  logic [15:0] mCnt;
  logic        mErr;

  task automatic tick();
    @(posedge UserCLK);
    #1;
  endtask

  task automatic do_reset(input logic [19:0] strobe);
    FrameData   = '0;
    FrameStrobe = strobe;
    Reset       = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    mPrev = 2'b11;
    mCfg  = '0;
    mIdx  = 1'b0;
    mCnt  = '0;
    mErr  = 1'b0;
    capQ.delete();
    pipeQ.delete();
  endtask

  // Drive one cycle and push the state the capture model expects after the edge
  task automatic apply(input logic [31:0] data, input logic [19:0] strobe);
    logic [1:0] rise;
    capEnt_t    e;
    FrameData   = data;
    FrameStrobe = strobe;
    rise  = strobe[1:0] & ~mPrev;
    mPrev = strobe[1:0];
    e.write = (rise == 2'b01) || (rise == 2'b10);
    if (e.write) begin
      mIdx = rise[1];
      if (rise[1]) mCfg[63:32] = data;
      else         mCfg[31:0]  = data;
      if (mCnt != 16'hFFFF) mCnt = mCnt + 16'd1;
    end
    if ($countones(strobe) > 1) mErr = 1'b1;
    e.idx = mIdx;
    e.cfg = mCfg;
    e.cnt = mCnt;
    e.err = mErr;
    capQ.push_back(e);
    tick();
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    FrameData = '0;
    FrameStrobe = '0;
    #2 Reset = 1'b1;
    #1;
    checks++; if (cfg2 !== 64'h0) begin failures++; $display("FAIL reset_cfg got=%h exp=0", cfg2); end
    checks++; if ({wr2, idx2, err2} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {wr2, idx2, err2}); end
    checks++; if (cnt2 !== 16'h0) begin failures++; $display("FAIL reset_count got=%h exp=0", cnt2); end
    checks++; if ({data2, strobe2} !== 52'h0) begin failures++; $display("FAIL reset_pipe got=%h exp=0", {data2, strobe2}); end
    checks++; if (clkO2 !== UserCLK) begin failures++; $display("FAIL clkbuf_low got=%b exp=%b", clkO2, UserCLK); end
    tick();
    checks++; if (clkO0 !== UserCLK) begin failures++; $display("FAIL clkbuf_high got=%b exp=%b", clkO0, UserCLK); end
    tick();
    Reset = 1'b0;
    tick();
    checks++; if ({cfg0, wr0, cnt0, err0} !== 82'h0) begin failures++; $display("FAIL reset_dut0 got=%h exp=0", {cfg0, wr0, cnt0, err0}); end
  endtask

  task automatic test_pipeline();
    pipeEnt_t pe;
    logic [31:0] d;
    logic [19:0] s;
    do_reset(20'h0);
    pipeQ.push_back('0);
    pipeQ.push_back('0);
    for (int c = 0; c < 12; c++) begin
      d = (c == 0) ? 32'hA5A5_0001 : ((c < 4) ? 32'h0 : $urandom());
      s = (c < 4) ? 20'h0 : (20'($urandom()) & 20'hFFFFC);
      FrameData = d;
      FrameStrobe = s;
      pipeQ.push_back({d, s});
      #1;
      pe = pipeQ.pop_front();
      checks++; if ({data2, strobe2} !== {pe.d, pe.s}) begin failures++; $display("FAIL pipe2 cyc=%0d got=%h/%h exp=%h/%h", c, data2, strobe2, pe.d, pe.s); end
      checks++; if ({data0, strobe0} !== {d, s}) begin failures++; $display("FAIL pipe0 cyc=%0d got=%h/%h exp=%h/%h", c, data0, strobe0, d, s); end
      if (c < 4) begin
        checks++; if (data2 !== ((c == 2) ? 32'hA5A5_0001 : 32'h0)) begin failures++; $display("FAIL pipe2_single cyc=%0d got=%h", c, data2); end
      end
      tick();
    end
    FrameData = 32'h1111_2222;
    FrameStrobe = 20'h00010;
    tick();
    FrameData = 32'h3333_4444;
    #2 Reset = 1'b1;
    #1;
    checks++; if ({data2, strobe2} !== 52'h0) begin failures++; $display("FAIL pipe_midreset got=%h exp=0", {data2, strobe2}); end
    FrameData = '0;
    FrameStrobe = '0;
    tick();
    Reset = 1'b0;
    pipeQ.delete();
    pipeQ.push_back('0);
    pipeQ.push_back('0);
    for (int c = 0; c < 4; c++) begin
      pipeQ.push_back('0);
      #1;
      pe = pipeQ.pop_front();
      checks++; if ({data2, strobe2} !== {pe.d, pe.s}) begin failures++; $display("FAIL pipe_flush cyc=%0d got=%h/%h exp=%h/%h", c, data2, strobe2, pe.d, pe.s); end
      tick();
    end
  endtask

  task automatic test_hold_capture();
    capEnt_t e;
    int pulses = 0;
    logic [19:0] seq [7] = '{20'h0, 20'h1, 20'h1, 20'h1, 20'h1, 20'h1, 20'h0};
    do_reset(20'h0);
    for (int c = 0; c < 7; c++) begin
      apply(32'hDEAD_BEEF, seq[c]);
      e = capQ.pop_front();
      if (wr2 === 1'b1) pulses++;
      checks++; if ({wr2, idx2, cfg2, cnt2, err2} !== e) begin failures++; $display("FAIL hold_capture cyc=%0d got wr=%b idx=%b cfg=%h cnt=%h err=%b exp wr=%b idx=%b cfg=%h cnt=%h err=%b", c, wr2, idx2, cfg2, cnt2, err2, e.write, e.idx, e.cfg, e.cnt, e.err); end
    end
    checks++; if (cfg2[31:0] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL hold_cfg got=%h exp=deadbeef", cfg2[31:0]); end
    checks++; if ({pulses, idx2, cnt2} !== {32'd1, 1'b0, 16'd1}) begin failures++; $display("FAIL hold_pulses got pulses=%0d idx=%b cnt=%0d exp 1/0/1", pulses, idx2, cnt2); end
  endtask

  task automatic test_multi_strobe();
    capEnt_t e;
    logic [19:0] seq [5] = '{20'h0, 20'h3, 20'h3, 20'h0, 20'h0};
    do_reset(20'h0);
    for (int c = 0; c < 5; c++) begin
      apply(32'h5555_0000 + 32'(c), seq[c]);
      e = capQ.pop_front();
      checks++; if ({wr2, idx2, cfg2, cnt2, err2} !== e) begin failures++; $display("FAIL multi_strobe cyc=%0d got wr=%b idx=%b cfg=%h cnt=%h err=%b exp wr=%b idx=%b cfg=%h cnt=%h err=%b", c, wr2, idx2, cfg2, cnt2, err2, e.write, e.idx, e.cfg, e.cnt, e.err); end
    end
    checks++; if ({cfg2, cnt2, err2} !== {64'h0, 16'h0, 1'b1}) begin failures++; $display("FAIL multi_sticky got cfg=%h cnt=%h err=%b exp 0/0/1", cfg2, cnt2, err2); end
    do_reset(20'h0);
    checks++; if (err2 !== 1'b0) begin failures++; $display("FAIL multi_clear got=%b exp=0", err2); end
  endtask

  task automatic test_reset_held_strobe();
    capEnt_t e;
    logic [31:0] dat [5] = '{32'hFFFF_0000, 32'hFFFF_0001, 32'h0, 32'h1234, 32'h9999};
    logic [19:0] seq [5] = '{20'h2, 20'h2, 20'h0, 20'h2, 20'h2};
    do_reset(20'h2);
    for (int c = 0; c < 5; c++) begin
      apply(dat[c], seq[c]);
      e = capQ.pop_front();
      checks++; if ({wr2, idx2, cfg2, cnt2, err2} !== e) begin failures++; $display("FAIL held_strobe cyc=%0d got wr=%b idx=%b cfg=%h cnt=%h err=%b exp wr=%b idx=%b cfg=%h cnt=%h err=%b", c, wr2, idx2, cfg2, cnt2, err2, e.write, e.idx, e.cfg, e.cnt, e.err); end
    end
    checks++; if ({cfg2, idx2, cnt2} !== {32'h1234, 32'h0, 1'b1, 16'd1}) begin failures++; $display("FAIL held_cfg got cfg=%h idx=%b cnt=%0d", cfg2, idx2, cnt2); end
  endtask

  task automatic test_nonlocal();
    capEnt_t e;
    logic [31:0] dat [4] = '{32'h0, 32'hCAFE_0001, 32'h0BAD_F00D, 32'h7777_7777};
    logic [19:0] seq [4] = '{20'h0, 20'h80000, 20'h80001, 20'h00004};
    do_reset(20'h0);
    for (int c = 0; c < 4; c++) begin
      apply(dat[c], seq[c]);
      e = capQ.pop_front();
      checks++; if ({wr2, idx2, cfg2, cnt2, err2} !== e) begin failures++; $display("FAIL nonlocal2 cyc=%0d got wr=%b idx=%b cfg=%h cnt=%h err=%b exp wr=%b idx=%b cfg=%h cnt=%h err=%b", c, wr2, idx2, cfg2, cnt2, err2, e.write, e.idx, e.cfg, e.cnt, e.err); end
      checks++; if ({wr0, idx0, cfg0, cnt0, err0} !== e) begin failures++; $display("FAIL nonlocal0 cyc=%0d got wr=%b idx=%b cfg=%h cnt=%h err=%b exp wr=%b idx=%b cfg=%h cnt=%h err=%b", c, wr0, idx0, cfg0, cnt0, err0, e.write, e.idx, e.cfg, e.cnt, e.err); end
      if (c == 1) begin
        checks++; if ({cfg0, cnt0, err0} !== 81'h0) begin failures++; $display("FAIL top_strobe got cfg=%h cnt=%h err=%b exp 0", cfg0, cnt0, err0); end
      end
    end
    checks++; if ({cfg2[31:0], err2} !== {32'h0BAD_F00D, 1'b1}) begin failures++; $display("FAIL mixed_capture got cfg=%h err=%b exp 0badf00d/1", cfg2[31:0], err2); end
  endtask

  task automatic test_saturation();
    capEnt_t e;
    int pulses = 0;
    do_reset(20'h0);
    apply(32'h0, 20'h0);
    e = capQ.pop_front();
    for (int i = 0; i < 65534; i++) begin
      apply(32'(i), (i % 2 == 0) ? 20'h1 : 20'h2);
      e = capQ.pop_front();
    end
    checks++; if (cnt2 !== 16'hFFFE) begin failures++; $display("FAIL sat_preload got=%h exp=fffe", cnt2); end
    for (int i = 0; i < 3; i++) begin
      apply(32'hF000_0000 + 32'(i), (i % 2 == 0) ? 20'h1 : 20'h2);
      e = capQ.pop_front();
      if (wr2 === 1'b1) pulses++;
      checks++; if ({wr2, idx2, cfg2, cnt2, err2} !== e) begin failures++; $display("FAIL saturation cyc=%0d got wr=%b idx=%b cfg=%h cnt=%h err=%b exp wr=%b idx=%b cfg=%h cnt=%h err=%b", i, wr2, idx2, cfg2, cnt2, err2, e.write, e.idx, e.cfg, e.cnt, e.err); end
    end
    checks++; if ({pulses, cnt2} !== {32'd3, 16'hFFFF}) begin failures++; $display("FAIL sat_final got pulses=%0d cnt=%h exp 3/ffff", pulses, cnt2); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pipeline();
    test_hold_capture();
    test_multi_strobe();
    test_reset_held_strobe();
    test_nonlocal();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
